// File: rtl/voting_pkg.sv
// Shared types and helpers for the parametrised voting machine.
package voting_pkg;

   localparam int MAX_CAND = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VOTING,
      S_COOLDOWN,
      S_CLOSED,
      S_TALLY,
      S_RESULT,
      S_LOCKED
   } svm_state_t;

   // Index width for n candidates, never narrower than one bit.
   function automatic int idx_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   // True when exactly one ballot button is pressed.
   function automatic logic is_one_hot(input logic [MAX_CAND-1:0] v);
      int pop;
      pop = 0;
      for (int i = 0; i < MAX_CAND; i++) begin
         pop += int'(v[i]);
      end
      return (pop == 1);
   endfunction

endpackage

// File: rtl/secure_voting_machine_n_tally_scan.sv
// Sequential winner search: one candidate per cycle, ties kept at the lowest index.
// Candidate 0 is loaded as the initial best on start, so the scan finishes
// in NUM_CAND cycles including the start cycle.
module svm_tally_scan
#(
   parameter int NUM_CAND = 4,
   parameter int COUNT_W  = 8,
   parameter int IDX_W    = 2
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [NUM_CAND*COUNT_W-1:0] counts,
   output logic [IDX_W-1:0]            winner,
   output logic                        tie,
   output logic                        done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

   logic                active;
   logic [IDX_W-1:0]    idx;
   logic [COUNT_W-1:0]  best;
   logic [COUNT_W-1:0]  cur;

   // Count of the candidate currently under inspection.
   always_comb begin
      cur = counts[int'(idx)*COUNT_W +: COUNT_W];
   end

   // Scan registers; done pulses for one cycle when the last index is compared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active <= 1'b0;
         idx    <= '0;
         best   <= '0;
         winner <= '0;
         tie    <= 1'b0;
         done   <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         idx    <= IDX_W'(1);
         best   <= counts[COUNT_W-1:0];
         winner <= '0;
         tie    <= 1'b0;
         done   <= 1'b0;
      end else if (active) begin
         if (cur > best) begin
            best   <= cur;
            winner <= idx;
            tie    <= 1'b0;
         end else if (cur == best) begin
            tie <= 1'b1;
         end
         if (idx == LAST_IDX) begin
            active <= 1'b0;
            done   <= 1'b1;
         end else begin
            idx <= idx + 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/secure_voting_machine_n.sv
// Parametrised secure voting machine: admin auth with lockout, one-hot ballots,
// saturating tallies, post-vote cooldown and a sequential winner scan.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | waiting for admin authentication
// S_VOTING   | ballots accepted
// S_COOLDOWN | busy window after an accepted ballot
// S_CLOSED   | poll closed, counts frozen
// S_TALLY    | winner scan running
// S_RESULT   | winner/tie final, terminal until reset
// S_LOCKED   | too many wrong passwords, terminal until reset
module secure_voting_machine_n
   import voting_pkg::*;
#(
   parameter int               NUM_CAND = 4,
   parameter int               COUNT_W  = 8,
   parameter int               PASS_W   = 4,
   parameter logic [PASS_W-1:0] PASSWORD = 4'b1010,
   parameter int               MAX_FAIL = 3,
   parameter int               BUSY_CYC = 2,
   localparam int              IDX_W    = idx_width(NUM_CAND)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [PASS_W-1:0]           admin_password,
   input  logic                        enable_admin,
   input  logic [NUM_CAND-1:0]         vote,
   input  logic                        close_poll,
   input  logic                        result_mode,
   output logic [NUM_CAND*COUNT_W-1:0] counts,
   output logic [IDX_W-1:0]            winner,
   output logic                        tie,
   output logic                        result_valid,
   output logic                        voting_enabled,
   output logic                        busy,
   output logic                        locked,
   output logic                        invalid_vote
);

   localparam int CD_W = (BUSY_CYC < 2) ? 1 : $clog2(BUSY_CYC + 1);

   svm_state_t            state;
   logic [NUM_CAND-1:0]   vote_q;
   logic                  admin_q;
   logic [2:0]            fail_cnt;
   logic [CD_W-1:0]       cd_cnt;
   logic [COUNT_W-1:0]    tally [NUM_CAND];

   logic                  admin_edge;
   logic                  ballot_new;
   logic                  ballot_one_hot;
   logic                  ballot_accept;
   logic                  tally_start;
   logic [IDX_W-1:0]      scan_winner;
   logic                  scan_tie;
   logic                  scan_done;

   // Edge detection and ballot qualification; close_poll outranks a same-cycle ballot.
   always_comb begin
      admin_edge     = enable_admin & ~admin_q;
      ballot_new     = |(vote & ~vote_q);
      ballot_one_hot = is_one_hot(MAX_CAND'(vote));
      ballot_accept  = (state == S_VOTING) && ballot_new && ballot_one_hot && !close_poll;
      tally_start    = (state == S_CLOSED) && result_mode;
   end

   // Previous-cycle copies of the strobes; tracked in every state so a held button never re-fires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         admin_q <= 1'b0;
         vote_q  <= '0;
      end else begin
         admin_q <= enable_admin;
         vote_q  <= vote;
      end
   end

   // Saturating per-candidate tallies.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
      end else if (ballot_accept) begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if (vote[i] && (tally[i] != '1)) tally[i] <= tally[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_flat
      assign counts[g*COUNT_W +: COUNT_W] = tally[g];
   end

   // Control FSM with registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         fail_cnt       <= '0;
         cd_cnt         <= '0;
         winner         <= '0;
         tie            <= 1'b0;
         result_valid   <= 1'b0;
         voting_enabled <= 1'b0;
         busy           <= 1'b0;
         locked         <= 1'b0;
         invalid_vote   <= 1'b0;
      end else begin
         invalid_vote <= 1'b0;
         case (state)
            S_IDLE: begin
               if (admin_edge) begin
                  if (admin_password == PASSWORD) begin
                     state          <= S_VOTING;
                     fail_cnt       <= '0;
                     voting_enabled <= 1'b1;
                  end else begin
                     fail_cnt <= fail_cnt + 1'b1;
                     if (fail_cnt == 3'(MAX_FAIL - 1)) begin
                        state  <= S_LOCKED;
                        locked <= 1'b1;
                     end
                  end
               end
            end
            S_VOTING: begin
               if (close_poll) begin
                  state          <= S_CLOSED;
                  voting_enabled <= 1'b0;
               end else if (ballot_new) begin
                  if (ballot_one_hot) begin
                     state          <= S_COOLDOWN;
                     cd_cnt         <= CD_W'(BUSY_CYC - 1);
                     voting_enabled <= 1'b0;
                     busy           <= 1'b1;
                  end else begin
                     invalid_vote <= 1'b1;
                  end
               end
            end
            S_COOLDOWN: begin
               if (cd_cnt == '0) begin
                  state          <= S_VOTING;
                  busy           <= 1'b0;
                  voting_enabled <= 1'b1;
               end else begin
                  cd_cnt <= cd_cnt - 1'b1;
               end
            end
            S_CLOSED: begin
               if (result_mode) begin
                  state <= S_TALLY;
                  busy  <= 1'b1;
               end
            end
            S_TALLY: begin
               if (scan_done) begin
                  state        <= S_RESULT;
                  busy         <= 1'b0;
                  winner       <= scan_winner;
                  tie          <= scan_tie;
                  result_valid <= 1'b1;
               end
            end
            S_RESULT: state <= S_RESULT;
            S_LOCKED: state <= S_LOCKED;
            default:  state <= S_IDLE;
         endcase
      end
   end

   svm_tally_scan #(
      .NUM_CAND (NUM_CAND),
      .COUNT_W  (COUNT_W),
      .IDX_W    (IDX_W)
   ) u_scan (
      .clk    (clk),
      .reset  (reset),
      .start  (tally_start),
      .counts (counts),
      .winner (scan_winner),
      .tie    (scan_tie),
      .done   (scan_done)
   );

endmodule

// File: doc/secure_voting_machine_n.md
# secure_voting_machine_n

Parametrised successor of the three-candidate secure voting machine. Supports `NUM_CAND` candidates and saturating `COUNT_W`-bit tallies. Adds password-lockout after repeated failures, rejection of multi-hot ballots, and a configurable post-vote busy window. The winner is found with a sequential tally scan that reports ties explicitly. Sits between the ballot-panel inputs and the result display/readout logic.

## Interface
Parameters:
- `NUM_CAND`, 4, number of candidates (2..16)
- `COUNT_W`, 8, width of each per-candidate counter
- `PASS_W`, 4, admin password width
- `PASSWORD`, 4'b1010, admin password value
- `MAX_FAIL`, 3, consecutive wrong passwords before lockout (1..7)
- `BUSY_CYC`, 2, cooldown cycles after each accepted vote (≥1)

Ports (`IDX_W` = max(1, $clog2(NUM_CAND))):
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `admin_password`  in  PASS_W  password presented with `enable_admin`
- `enable_admin`  in  1  authentication strobe, rising-edge detected
- `vote`  in  NUM_CAND  ballot buttons, bit i = candidate i, rising-edge detected
- `close_poll`  in  1  level; ends voting
- `result_mode`  in  1  level; requests tally after close
- `counts`  out  NUM_CAND*COUNT_W  flattened tallies, candidate i at [i*COUNT_W +: COUNT_W]
- `winner`  out  IDX_W  winning candidate index
- `tie`  out  1  top count shared by ≥2 candidates
- `result_valid`  out  1  `winner`/`tie` final
- `voting_enabled`  out  1  ballots accepted this cycle
- `busy`  out  1  cooldown or tally in progress
- `locked`  out  1  lockout active
- `invalid_vote`  out  1  one-cycle pulse on rejected multi-hot ballot

## Operation
- States: IDLE, VOTING, COOLDOWN, CLOSED, TALLY, RESULT, LOCKED.
- Reset: state IDLE; all counts, fail counter, `winner`, `tie`, `result_valid`, `voting_enabled`, `busy`, `locked`, `invalid_vote` = 0. Edge-detect registers clear to 0.
- IDLE, on `enable_admin` rising edge:
  - password match → VOTING, fail counter cleared.
  - mismatch → fail counter +1; reaching `MAX_FAIL` → LOCKED.
- LOCKED: `locked`=1 and all inputs are ignored. Only reset exits.
- VOTING: `voting_enabled`=1. A new ballot is `vote & ~vote_q` ≠ 0.
  - If `vote` is exactly one-hot: the counter of that candidate increments, saturating at 2^COUNT_W−1. Then → COOLDOWN.
  - If `vote` has ≥2 bits set: `invalid_vote` pulses, nothing is counted, state stays VOTING.
  - `close_poll`=1 → CLOSED. It takes priority: a ballot edge in the same cycle is discarded.
- COOLDOWN: `busy`=1, `voting_enabled`=0 for exactly `BUSY_CYC` cycles, then → VOTING. Edges arriving here are lost. `vote_q` keeps tracking, so a button held through cooldown is not recounted.
- CLOSED: counts frozen. `result_mode`=1 → TALLY.
- TALLY: `busy`=1. Scans one candidate per cycle, index 0..NUM_CAND−1.
  - Strictly greater count replaces best and clears the tie flag.
  - Equal count sets the tie flag.
  - Ties resolve to the lowest index.
  - All-zero counts give `winner`=0, `tie`=1.
- RESULT: `result_valid`=1; `winner`/`tie` held. Terminal until reset; further `result_mode`/`vote` are ignored.
- Asynchronous reset in any state, including mid-TALLY or COOLDOWN, returns the block to the reset values immediately.

## Timing
- Input sampled in cycle n means state and outputs are updated and visible in cycle n+1; all outputs are registered.
- Authentication: `enable_admin` rising edge at n → `voting_enabled`=1 at n+1.
- Vote: edge at n → count updated, `busy`=1, `voting_enabled`=0 at n+1..n+BUSY_CYC. `voting_enabled`=1 again at n+BUSY_CYC+1.
- Tally: `result_mode` sampled in CLOSED at t → `busy` at t+1..t+NUM_CAND. `result_valid`=1 at t+NUM_CAND+1.
- `invalid_vote` is high for exactly cycle n+1.

## Structure
- Package `voting_pkg` holds:
  - the state enum `svm_state_t`;
  - the `IDX_W` computation function;
  - the one-hot check function (popcount == 1).
- One sub-module, `svm_tally_scan`:
  - inputs: start, flattened counts;
  - outputs: winner, tie, done;
  - implements the sequential scan.
- Edge detection and counters stay in the top level.

## Test plan
All scenarios use default parameters.
1. Auth + votes: password 1010 → `voting_enabled`=1 next cycle. Pulse `vote`=0001, then 0010 after busy clears → counts 1/1/0/0. `busy` high 2 cycles after each vote.
2. Lockout: three pulses with password 0000 → `locked`=1 after the third. A further correct 1010 pulse has no effect. Reset clears `locked`.
3. Multi-hot: `vote`=0101 in VOTING → `invalid_vote` one-cycle pulse, counts unchanged. A held `vote`=0001 through cooldown counts once.
4. Saturation: `COUNT_W`=2, 5 votes for candidate 2 → count stays 3.
5. Tally: counts 2/5/5/1, close, `result_mode`=1 → `result_valid` 5 cycles later, `winner`=1, `tie`=1. With counts 0/0/3/0 → `winner`=2, `tie`=0.
6. Reset mid-TALLY: assert `reset` low during scan cycle 2 → all outputs 0 immediately; state IDLE.
